// File: rtl/col_output_packer.sv
// col_output_packer
// Collects per-lane systolic column results into rows, queues complete rows
// in a small FIFO and streams each row out as BEATS words of OW bits.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   in_r[NLANES]      per-lane result data
//   in_v[NLANES]      per-lane result valid
//   flush             commit the partially captured row (missing lanes = 0)
//   rread             consumer accepts the current beat
//   clr_ovf           clears the sticky overflow flag
//   out_r             current output beat (0 when nothing is valid)
//   rvalid            out_r holds a valid beat
//   last              current beat is the final beat of its row
//   level             number of complete rows held in the FIFO
//   ovf               sticky overflow / dropped-result indicator
module col_output_packer #(
  parameter int unsigned NLANES = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned OW     = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [DW-1:0]                in_r [NLANES],
  input  logic                         in_v [NLANES],
  input  logic                         flush,
  input  logic                         rread,
  input  logic                         clr_ovf,
  output logic [OW-1:0]                out_r,
  output logic                         rvalid,
  output logic                         last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         ovf
);

  localparam int unsigned ROW_W  = NLANES * DW;
  localparam int unsigned BEATS  = ROW_W / OW;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Row capture state
  logic [NLANES-1:0] cap_q, cap_d;
  logic [DW-1:0]     hold_q [NLANES];
  logic [DW-1:0]     hold_d [NLANES];
  logic              flush_pend_q, flush_pend_d;
  logic              ovf_q, ovf_d;

  // Row FIFO and drain state
  logic [ROW_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              rvalid_c;
  logic              last_beat_c;
  logic              xfer_c;
  logic              pop_final_c;
  logic              full_c;
  logic              row_ready_c;
  logic              commit_c;
  logic              drop_c;
  logic [ROW_W-1:0]  row_wdata_c;
  logic [ROW_W-1:0]  head_row_c;
  logic [OW-1:0]     out_c;

  // Drain handshake and commit decision
  always_comb begin
    rvalid_c    = (level_q != '0);
    last_beat_c = (beat_q == BEAT_W'(BEATS - 1));
    xfer_c      = rvalid_c && rread;
    pop_final_c = xfer_c && last_beat_c;
    full_c      = (level_q == LVL_W'(DEPTH));
    row_ready_c = (&cap_q) || (flush_pend_q && (|cap_q));
    // A final-beat pop in the same cycle frees the slot the commit needs.
    commit_c    = row_ready_c && (!full_c || pop_final_c);
  end

  // Lane capture, drop detection and row assembly
  always_comb begin
    cap_d       = commit_c ? '0 : cap_q;
    drop_c      = 1'b0;
    row_wdata_c = '0;
    for (int i = 0; i < int'(NLANES); i++) begin
      hold_d[i] = hold_q[i];
      // hold is not cleared on commit, so stale lanes are masked by cap.
      row_wdata_c[i*DW +: DW] = cap_q[i] ? hold_q[i] : '0;
      if (in_v[i]) begin
        if (commit_c || !cap_q[i]) begin
          hold_d[i] = in_r[i];
          cap_d[i]  = 1'b1;
        end else begin
          drop_c = 1'b1;
        end
      end
    end
  end

  // Flush pending, overflow, pointers, level and beat index
  always_comb begin
    flush_pend_d = flush_pend_q;
    ovf_d        = ovf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    beat_d       = beat_q;

    // A flush only sticks if something will be in the row after this edge.
    if (flush) begin
      flush_pend_d = |cap_d;
    end else if (commit_c) begin
      flush_pend_d = 1'b0;
    end

    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    if (commit_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_final_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({commit_c, pop_final_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (xfer_c) begin
      beat_d = last_beat_c ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_q        <= '0;
      flush_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      beat_q       <= '0;
      for (int i = 0; i < int'(NLANES); i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      cap_q        <= cap_d;
      flush_pend_q <= flush_pend_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      beat_q       <= beat_d;
      for (int i = 0; i < int'(NLANES); i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  // Row storage; contents are only meaningful below level, so no reset needed
  always_ff @(posedge clk) begin
    if (commit_c) begin
      mem_q[wr_ptr_q] <= row_wdata_c;
    end
  end

  // Beat selection from the head row, zero when idle
  always_comb begin
    head_row_c = mem_q[rd_ptr_q];
    out_c      = '0;
    if (rvalid_c) begin
      for (int b = 0; b < int'(BEATS); b++) begin
        if (beat_q == BEAT_W'(b)) begin
          out_c = head_row_c[b*OW +: OW];
        end
      end
    end
  end

  assign out_r  = out_c;
  assign rvalid = rvalid_c;
  assign last   = rvalid_c && last_beat_c;
  assign level  = level_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_col_output_packer.sv
// Testbench for col_output_packer: directed scenarios plus randomized traffic
// checked against a queue-based row model.
module tb_col_output_packer;

  localparam int NL    = 8;
  localparam int DW    = 8;
  localparam int OW    = 32;
  localparam int DEPTH = 4;
  localparam int BEATS = NL * DW / OW;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] in_r [NL];
  logic          in_v [NL];
  logic          flush, rread, clr_ovf;
  logic [OW-1:0] out_r;
  logic          rvalid, last, ovf;
  logic [2:0]    level;

  int checks = 0;
  int passed = 0;

  // Reference model: queue of committed rows plus the row under construction
  logic [NL*DW-1:0] mq[$];
  bit               mcap [NL];
  logic [DW-1:0]    mhold [NL];
  bit               mfp;
  bit               movf;
  int               mbeat;

  col_output_packer #(.NLANES(NL), .DW(DW), .OW(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .in_r(in_r), .in_v(in_v), .flush(flush),
    .rread(rread), .clr_ovf(clr_ovf), .out_r(out_r), .rvalid(rvalid),
    .last(last), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic idle();
    for (int i = 0; i < NL; i++) begin
      in_v[i] = 1'b0;
      in_r[i] = '0;
    end
    flush   = 1'b0;
    rread   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NL; i++) begin
      mcap[i]  = 1'b0;
      mhold[i] = '0;
    end
    mfp   = 1'b0;
    movf  = 1'b0;
    mbeat = 0;
  endtask

  function automatic bit m_rvalid();
    return mq.size() != 0;
  endfunction

  function automatic logic [OW-1:0] m_out();
    logic [NL*DW-1:0] h;
    if (mq.size() == 0) return '0;
    h = mq[0];
    return h[mbeat*OW +: OW];
  endfunction

  function automatic bit m_last();
    return (mq.size() != 0) && (mbeat == BEATS - 1);
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit rv, pop, allc, anyc, anyn, commit, drop;
    logic [NL*DW-1:0] row;
    rv   = mq.size() != 0;
    pop  = rv && rread && (mbeat == BEATS - 1);
    allc = 1'b1;
    anyc = 1'b0;
    anyn = 1'b0;
    drop = 1'b0;
    row  = '0;
    for (int i = 0; i < NL; i++) begin
      allc &= mcap[i];
      anyc |= mcap[i];
      if (mcap[i]) row[i*DW +: DW] = mhold[i];
    end
    commit = (allc || (mfp && anyc)) && ((mq.size() < DEPTH) || pop);
    if (commit) for (int i = 0; i < NL; i++) mcap[i] = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (in_v[i]) begin
        if (!mcap[i]) begin
          mcap[i]  = 1'b1;
          mhold[i] = in_r[i];
        end else begin
          drop = 1'b1;
        end
      end
      anyn |= mcap[i];
    end
    if (rv && rread) mbeat = pop ? 0 : mbeat + 1;
    if (pop) void'(mq.pop_front());
    if (commit) mq.push_back(row);
    if (flush) mfp = anyn;
    else if (commit) mfp = 1'b0;
    if (drop) movf = 1'b1;
    else if (clr_ovf) movf = 1'b0;
  endtask

  // Inputs are applied at the falling edge; outputs are read at the next one
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    model_reset();
    #3;
    checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%0h exp=0", rvalid); else passed++;
    checks++; if (last !== 1'b0) $display("FAIL reset_last got=%0h exp=0", last); else passed++;
    checks++; if (out_r !== '0) $display("FAIL reset_out_r got=%08h exp=0", out_r); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%0h exp=0", ovf); else passed++;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_row();
    idle();
    for (int i = 0; i < NL; i++) begin
      in_v[i] = 1'b1;
      in_r[i] = DW'(i + 1);
    end
    rread = 1'b1;
    cycle();
    idle();
    rread = 1'b1;
    checks++; if (rvalid !== 1'b0) $display("FAIL full_row_early_rvalid got=%0h exp=0", rvalid); else passed++;
    cycle();
    checks++; if (rvalid !== 1'b1) $display("FAIL full_row_rvalid got=%0h exp=1", rvalid); else passed++;
    checks++; if (out_r !== 32'h04030201) $display("FAIL full_row_beat0 got=%08h exp=04030201", out_r); else passed++;
    checks++; if (last !== 1'b0) $display("FAIL full_row_last0 got=%0h exp=0", last); else passed++;
    cycle();
    checks++; if (out_r !== 32'h08070605) $display("FAIL full_row_beat1 got=%08h exp=08070605", out_r); else passed++;
    checks++; if (last !== 1'b1) $display("FAIL full_row_last1 got=%0h exp=1", last); else passed++;
    cycle();
    idle();
    checks++; if (level !== 3'd0) $display("FAIL full_row_level_end got=%0d exp=0", level); else passed++;
    checks++; if (out_r !== '0) $display("FAIL full_row_idle_out got=%08h exp=0", out_r); else passed++;
  endtask

  task automatic test_diagonal();
    logic [DW-1:0] v [NL];
    for (int j = 0; j < NL; j++) begin
      idle();
      v[j]    = DW'($urandom);
      in_v[j] = 1'b1;
      in_r[j] = v[j];
      cycle();
    end
    idle();
    checks++; if (level !== 3'd0) $display("FAIL diag_level_pre got=%0d exp=0", level); else passed++;
    cycle();
    checks++; if (level !== 3'd1) $display("FAIL diag_level got=%0d exp=1", level); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL diag_ovf got=%0h exp=0", ovf); else passed++;
    checks++; if (out_r !== {v[3], v[2], v[1], v[0]}) $display("FAIL diag_beat0 got=%08h exp=%08h", out_r, {v[3], v[2], v[1], v[0]}); else passed++;
    rread = 1'b1;
    cycle();
    checks++; if (out_r !== {v[7], v[6], v[5], v[4]}) $display("FAIL diag_beat1 got=%08h exp=%08h", out_r, {v[7], v[6], v[5], v[4]}); else passed++;
    cycle();
    idle();
    checks++; if (level !== 3'd0) $display("FAIL diag_level_end got=%0d exp=0", level); else passed++;
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin
      in_v[i] = 1'b1;
      in_r[i] = DW'(i + 1);
    end
    cycle();
    idle();
    flush = 1'b1;
    cycle();
    idle();
    checks++; if (rvalid !== 1'b0) $display("FAIL flush_early_rvalid got=%0h exp=0", rvalid); else passed++;
    cycle();
    checks++; if (out_r !== 32'h00030201) $display("FAIL flush_beat0 got=%08h exp=00030201", out_r); else passed++;
    checks++; if (last !== 1'b0) $display("FAIL flush_last0 got=%0h exp=0", last); else passed++;
    rread = 1'b1;
    cycle();
    checks++; if (out_r !== 32'h0 || rvalid !== 1'b1) $display("FAIL flush_beat1 got=%08h/%0h exp=00000000/1", out_r, rvalid); else passed++;
    checks++; if (last !== 1'b1) $display("FAIL flush_last1 got=%0h exp=1", last); else passed++;
    cycle();
    idle();
    checks++; if (level !== 3'd0) $display("FAIL flush_level_end got=%0d exp=0", level); else passed++;
    // Flush of an empty row is forgotten and must not commit a later capture
    flush = 1'b1;
    cycle();
    idle();
    in_v[0] = 1'b1;
    in_r[0] = 8'h5A;
    cycle();
    idle();
    cycle();
    cycle();
    checks++; if (level !== 3'd0) $display("FAIL empty_flush_level got=%0d exp=0", level); else passed++;
    flush = 1'b1;
    cycle();
    idle();
    cycle();
    checks++; if (level !== 3'd1) $display("FAIL late_flush_level got=%0d exp=1", level); else passed++;
    checks++; if (out_r !== 32'h0000005A) $display("FAIL late_flush_beat0 got=%08h exp=0000005a", out_r); else passed++;
    rread = 1'b1;
    cycle();
    cycle();
    idle();
  endtask

  task automatic test_overflow();
    idle();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NL; i++) begin
        in_v[i] = 1'b1;
        in_r[i] = DW'($urandom);
      end
      cycle();
    end
    idle();
    cycle();
    cycle();
    checks++; if (level !== 3'd4) $display("FAIL ovf_level_full got=%0d exp=4", level); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_pre got=%0h exp=0", ovf); else passed++;
    in_v[3] = 1'b1;
    in_r[3] = 8'hEE;
    cycle();
    idle();
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_drop got=%0h exp=1", ovf); else passed++;
    in_v[5]  = 1'b1;
    clr_ovf  = 1'b1;
    cycle();
    idle();
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_set_wins got=%0h exp=1", ovf); else passed++;
    clr_ovf = 1'b1;
    cycle();
    idle();
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear got=%0h exp=0", ovf); else passed++;
    rread = 1'b1;
    cycle();
    checks++; if (level !== 3'd4 || last !== 1'b1) $display("FAIL ovf_mid_drain got=%0d/%0h exp=4/1", level, last); else passed++;
    cycle();
    checks++; if (level !== 3'd4) $display("FAIL held_commit_level got=%0d exp=4", level); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL held_commit_nodrop got=%0h exp=0", ovf); else passed++;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      checks++; if (out_r !== m_out() || last !== m_last()) $display("FAIL ovf_drain beat=%0d got=%08h/%0h exp=%08h/%0h", k, out_r, last, m_out(), m_last()); else passed++;
      cycle();
    end
    idle();
    checks++; if (level !== 3'd0) $display("FAIL ovf_level_end got=%0d exp=0", level); else passed++;
  endtask

  task automatic test_reset_mid();
    idle();
    in_v[0] = 1'b1;
    in_r[0] = 8'h11;
    cycle();
    for (int i = 0; i < NL; i++) begin
      in_v[i] = 1'b1;
      in_r[i] = DW'($urandom);
    end
    cycle();
    idle();
    cycle();
    rread = 1'b1;
    cycle();
    idle();
    checks++; if (last !== 1'b1 || ovf !== 1'b1) $display("FAIL rstmid_pre got=%0h/%0h exp=1/1", last, ovf); else passed++;
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0) $display("FAIL rstmid_rvalid got=%0h exp=0", rvalid); else passed++;
    checks++; if (last !== 1'b0) $display("FAIL rstmid_last got=%0h exp=0", last); else passed++;
    checks++; if (level !== 3'd0) $display("FAIL rstmid_level got=%0d exp=0", level); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL rstmid_ovf got=%0h exp=0", ovf); else passed++;
    checks++; if (out_r !== '0) $display("FAIL rstmid_out got=%08h exp=0", out_r); else passed++;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < NL; i++) begin
      in_v[i] = 1'b1;
      in_r[i] = DW'(8'h10 + i);
    end
    cycle();
    idle();
    cycle();
    checks++; if (level !== 3'd1 || out_r !== 32'h13121110) $display("FAIL rstmid_after got=%0d/%08h exp=1/13121110", level, out_r); else passed++;
    rread = 1'b1;
    cycle();
    checks++; if (out_r !== 32'h17161514 || last !== 1'b1) $display("FAIL rstmid_after_b1 got=%08h/%0h exp=17161514/1", out_r, last); else passed++;
    cycle();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NL; i++) begin
        in_v[i] = ($urandom_range(0, 9) < 4);
        in_r[i] = DW'($urandom);
      end
      flush   = ($urandom_range(0, 15) == 0);
      rread   = ($urandom_range(0, 1) == 1);
      clr_ovf = ($urandom_range(0, 15) == 0);
      cycle();
      checks++; if (rvalid !== m_rvalid()) $display("FAIL rand_rvalid cyc=%0d got=%0h exp=%0h", c, rvalid, m_rvalid()); else passed++;
      checks++; if (out_r !== m_out()) $display("FAIL rand_out cyc=%0d got=%08h exp=%08h", c, out_r, m_out()); else passed++;
      checks++; if (last !== m_last()) $display("FAIL rand_last cyc=%0d got=%0h exp=%0h", c, last, m_last()); else passed++;
      checks++; if (level !== 3'(mq.size())) $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", c, level, mq.size()); else passed++;
      checks++; if (ovf !== movf) $display("FAIL rand_ovf cyc=%0d got=%0h exp=%0h", c, ovf, movf); else passed++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_diagonal();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/col_output_packer.md
COL_OUTPUT_PACKER -- requirements
Module: col_output_packer

Interface
REQ-001 Parameter NLANES, default 8: number of systolic column lanes.
REQ-002 Parameter DW, default 8: bits per lane result.
REQ-003 Parameter OW, default 32: output word width; NLANES*DW SHALL be a multiple of OW (BEATS = NLANES*DW/OW).
REQ-004 Parameter DEPTH, default 4: row FIFO depth in complete rows, at least 2.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 in_r  in  NLANES x DW (unpacked array)  per-lane result data.
REQ-008 in_v  in  NLANES (unpacked array)  per-lane valid.
REQ-009 flush  in  1  commit the partially captured row, zero-filling missing lanes.
REQ-010 rread  in  1  consumer accepts the current beat.
REQ-011 clr_ovf  in  1  clears the overflow flag.
REQ-012 out_r  out  OW  current output beat.
REQ-013 rvalid  out  1  out_r holds a valid beat.
REQ-014 last  out  1  current beat is the final beat of its row.
REQ-015 level  out  clog2(DEPTH+1)  complete rows held in the FIFO.
REQ-016 ovf  out  1  sticky overflow/drop indicator.

Function
REQ-017 Capture: when in_v[i] is 1 and cap[i] is 0, hold[i] SHALL load in_r[i] and cap[i] SHALL set.
REQ-018 Drop: when in_v[i] is 1, cap[i] is 1, and no commit occurs that cycle, data SHALL be discarded and ovf set.
REQ-019 row_ready = (all cap set) OR (flush_pend AND any cap set); flush_pend sets on flush and clears on commit.
REQ-020 flush with no cap bit set (and none captured that cycle) SHALL clear flush_pend without committing.
REQ-021 Commit: when row_ready and the FIFO is not full, the row SHALL be written to the FIFO and all cap bits cleared; missing lanes SHALL be written as zero.
REQ-022 Capture and commit in the same cycle: a new in_v[i] SHALL be captured into the next row. It SHALL NOT count as a drop.
REQ-023 Full FIFO: a ready row SHALL be held, with cap unchanged, until space exists.
REQ-024 Space also exists when the final beat of the head row pops in the same cycle as the commit.
REQ-025 Latency: row completed at edge N, committed at edge N+1, rvalid high after edge N+1.
REQ-026 Packing: lane 0 SHALL occupy row bits [DW-1:0]; beat b SHALL carry row bits [b*OW +: OW].
REQ-027 Drain state: a beat index counts 0..BEATS-1. It SHALL advance on rvalid AND rread.
REQ-028 On transfer of beat BEATS-1, the head row SHALL pop and the index SHALL reset to 0.
REQ-029 last SHALL equal rvalid AND (index == BEATS-1).
REQ-030 rvalid SHALL equal (level != 0); rread while rvalid is 0 SHALL be ignored.
REQ-031 out_r SHALL be 0 while rvalid is 0.
REQ-032 level SHALL be +1 on commit only, -1 on final-beat pop only, and unchanged when both occur in the same cycle.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH.
REQ-034 A drop and clr_ovf in the same cycle SHALL leave ovf at 1 (set wins).

Reset
REQ-035 rstn low SHALL immediately clear cap, hold, flush_pend, FIFO pointers, level, beat index and ovf.
REQ-036 rstn low SHALL force rvalid, last and out_r to 0, regardless of clk.
REQ-037 A reset mid-row or mid-drain SHALL discard all buffered data; after release the block SHALL behave as from power-up.

Verification
REQ-038 All in_v high in one cycle, in_r[i]=i+1, rread=1 -> rvalid 2 cycles later; out_r 0x04030201 with last=0, then 0x08070605 with last=1; level returns to 0.
REQ-039 One-hot diagonal in_v (lane j valid in cycle j, 8 cycles) -> no ovf; one row committed the cycle after lane 7; level reaches 1.
REQ-040 rread=0, 5 full rows sent -> level=4; 5th row held; a further in_v on a captured lane sets ovf; draining 2 beats frees the slot and the held row commits.
REQ-041 Lanes 0-2 captured with values 1,2,3, then flush pulse -> row output 0x00030201 then 0x00000000 with last=1.
REQ-042 FIFO full, final beat popping while a new row completes -> level stays 4 and no drop occurs.
REQ-043 rstn asserted during beat 1 of a row -> rvalid, last, level and ovf read 0 before the next clk edge.
